// File: rtl/adex_spike_monitor.sv
// adex_spike_monitor: edge-detects the AdEx core's spike level, logs ISIs into a
// nibble-read FIFO and reports a windowed spike rate. Burst flag built only with ADEX_MON_BURST_EN.
module adex_spike_monitor #(
   parameter int WINDOW_CYCLES = 4096,
   parameter int FIFO_DEPTH    = 4,
   parameter int BURST_ISI     = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       spike_in,
   input  logic       rd_strobe,
   input  logic       clr_ovf,
   output logic [3:0] nibble_out,
   output logic       rec_valid,
   output logic       fifo_full,
   output logic       overflow,
   output logic [7:0] rate_out,
   output logic       rate_valid,
   output logic       burst_out
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = $clog2(WINDOW_CYCLES);

   logic        spike_prev;
   logic        spk_edge;
   logic [15:0] isi_cnt;

   assign spk_edge = spike_in & ~spike_prev & enable;

   always_ff @(posedge clk) begin
      if (reset) begin
         spike_prev <= 1'b0;
         isi_cnt    <= '0;
      end else begin
         spike_prev <= spike_in;
         if (enable) begin
            if (spk_edge)
               isi_cnt <= 16'd1;
            else if (isi_cnt != 16'hFFFF)
               isi_cnt <= isi_cnt + 16'd1;
         end
      end
   end

   logic [15:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [CW-1:0]    count, count_nxt;
   logic [1:0]       nib_idx, nib_nxt;
   logic             rd_ok, pop, push_ok, drop;
   logic [15:0]      head_nxt;
   logic [3:0][3:0]  head_nib;

   assign fifo_full  = (count == CW'(FIFO_DEPTH));
   assign rec_valid  = (count != '0);
   assign rd_ok      = rd_strobe & rec_valid;
   assign pop        = rd_ok & (nib_idx == 2'd3);
   assign push_ok    = spk_edge & (~fifo_full | pop);
   assign drop       = spk_edge & fifo_full & ~pop;
   assign count_nxt  = count + CW'(push_ok) - CW'(pop);
   assign rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
   assign nib_nxt    = rd_ok ? nib_idx + 2'd1 : nib_idx;

   // nibble_out is built from next-state so it lines up with rec_valid; the new
   // head can be the record being written this very cycle.
   assign head_nxt = (push_ok && (rd_ptr_nxt == wr_ptr)) ? isi_cnt : mem[rd_ptr_nxt];
   assign head_nib = head_nxt;

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= isi_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         nib_idx    <= 2'd0;
         nibble_out <= 4'd0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PW'(1);
         rd_ptr     <= rd_ptr_nxt;
         count      <= count_nxt;
         nib_idx    <= nib_nxt;
         nibble_out <= (count_nxt == '0) ? 4'd0 : head_nib[2'd3 - nib_nxt];
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

   logic [WW-1:0] win_cnt;
   logic [7:0]    spk_cnt, spk_sum;
   logic          win_end;

   assign win_end = (win_cnt == WW'(WINDOW_CYCLES - 1));
   assign spk_sum = (spk_cnt == 8'hFF) ? 8'hFF : spk_cnt + {7'd0, spk_edge};

   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt    <= '0;
         spk_cnt    <= 8'd0;
         rate_out   <= 8'd0;
         rate_valid <= 1'b0;
      end else begin
         rate_valid <= 1'b0;
         if (enable) begin
            if (win_end) begin
               rate_out   <= spk_sum;
               rate_valid <= 1'b1;
               spk_cnt    <= 8'd0;
               win_cnt    <= '0;
            end else begin
               spk_cnt <= spk_sum;
               win_cnt <= win_cnt + WW'(1);
            end
         end
      end
   end

`ifdef ADEX_MON_BURST_EN
   logic [1:0] run_cnt, run_nxt;

   // Consecutive short ISIs, saturating at 3.
   always_comb begin
      run_nxt = run_cnt;
      if (spk_edge) begin
         if (isi_cnt <= 16'(BURST_ISI))
            run_nxt = (run_cnt == 2'd3) ? 2'd3 : run_cnt + 2'd1;
         else
            run_nxt = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_cnt   <= 2'd0;
         burst_out <= 1'b0;
      end else begin
         run_cnt   <= run_nxt;
         burst_out <= (run_nxt >= 2'd2);
      end
   end
`else
   localparam int unused_burst_isi = BURST_ISI;
   assign burst_out = 1'b0;
`endif

endmodule

// File: tb/tb_adex_spike_monitor.sv
// Bench for adex_spike_monitor: directed test-plan steps then random traffic, all
// outputs checked every cycle against a queue-based reference model.
module tb_adex_spike_monitor;
   localparam int DEPTH = 4;
   localparam int W_S   = 16;
   localparam int W_B   = 1024;
   localparam int B_ISI = 64;
`ifdef ADEX_MON_BURST_EN
   localparam bit BURST_ON = 1'b1;
`else
   localparam bit BURST_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1, enable = 1'b0, spike_in = 1'b0, rd_strobe = 1'b0, clr_ovf = 1'b0;
   logic [3:0] nib_s, nib_b;
   logic [7:0] rate_s, rate_b;
   logic rv_s, rv_b, full_s, full_b, ovf_s, ovf_b, rvld_s, rvld_b, burst_s, burst_b;

   int total = 0;
   int bad = 0;

   int q[$];
   int m_prev, m_isi, m_nib, m_ovf, m_run, m_burst;
   int m_win[2], m_spk[2], m_rate[2], m_rv[2];

   always #5 clk = ~clk;

   adex_spike_monitor #(.WINDOW_CYCLES(W_S), .FIFO_DEPTH(DEPTH), .BURST_ISI(B_ISI)) dut (
      .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
      .rd_strobe(rd_strobe), .clr_ovf(clr_ovf), .nibble_out(nib_s),
      .rec_valid(rv_s), .fifo_full(full_s), .overflow(ovf_s),
      .rate_out(rate_s), .rate_valid(rvld_s), .burst_out(burst_s));

   adex_spike_monitor #(.WINDOW_CYCLES(W_B), .FIFO_DEPTH(DEPTH), .BURST_ISI(B_ISI)) dut_big (
      .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
      .rd_strobe(rd_strobe), .clr_ovf(clr_ovf), .nibble_out(nib_b),
      .rec_valid(rv_b), .fifo_full(full_b), .overflow(ovf_b),
      .rate_out(rate_b), .rate_valid(rvld_b), .burst_out(burst_b));

   function automatic int wlen(int k);
      return (k == 0) ? W_S : W_B;
   endfunction

   function automatic int sat(int v, int lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_prev = 0; m_isi = 0; m_nib = 0; m_ovf = 0; m_run = 0; m_burst = 0;
      for (int k = 0; k < 2; k++) begin
         m_win[k] = 0; m_spk[k] = 0; m_rate[k] = 0; m_rv[k] = 0;
      end
   endtask

   // One clock of the block's behaviour, from the current input values.
   task automatic model_clock();
      int e;
      bit pop, drop;
      e    = (spike_in && m_prev == 0 && enable) ? 1 : 0;
      pop  = rd_strobe && q.size() != 0 && m_nib == 3;
      drop = 1'b0;
      if (rd_strobe && q.size() != 0) m_nib = (m_nib + 1) % 4;
      if (pop) void'(q.pop_front());
      if (e != 0) begin
         if (q.size() < DEPTH) q.push_back(m_isi);
         else drop = 1'b1;
         m_run   = (m_isi <= B_ISI) ? sat(m_run + 1, 3) : 0;
         m_burst = (BURST_ON && m_run >= 2) ? 1 : 0;
      end
      if (drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      for (int k = 0; k < 2; k++) begin
         m_rv[k] = 0;
         if (enable) begin
            if (m_win[k] == wlen(k) - 1) begin
               m_rate[k] = sat(m_spk[k] + e, 255);
               m_spk[k]  = 0;
               m_win[k]  = 0;
               m_rv[k]   = 1;
            end else begin
               m_spk[k] = sat(m_spk[k] + e, 255);
               m_win[k]++;
            end
         end
      end
      if (enable) m_isi = (e != 0) ? 1 : sat(m_isi + 1, 65535);
      m_prev = spike_in ? 1 : 0;
   endtask

   task automatic check_all();
      int en;
      en = (q.size() == 0) ? 0 : ((q[0] >> (4 * (3 - m_nib))) & 15);
      chk("nibble_out", 32'(nib_s), en);
      chk("nibble_out_big", 32'(nib_b), en);
      chk("rec_valid", 32'(rv_s), (q.size() != 0) ? 1 : 0);
      chk("rec_valid_big", 32'(rv_b), (q.size() != 0) ? 1 : 0);
      chk("fifo_full", 32'(full_s), (q.size() == DEPTH) ? 1 : 0);
      chk("fifo_full_big", 32'(full_b), (q.size() == DEPTH) ? 1 : 0);
      chk("overflow", 32'(ovf_s), m_ovf);
      chk("overflow_big", 32'(ovf_b), m_ovf);
      chk("rate_out", 32'(rate_s), m_rate[0]);
      chk("rate_out_big", 32'(rate_b), m_rate[1]);
      chk("rate_valid", 32'(rvld_s), m_rv[0]);
      chk("rate_valid_big", 32'(rvld_b), m_rv[1]);
      chk("burst_out", 32'(burst_s), m_burst);
      chk("burst_out_big", 32'(burst_b), m_burst);
   endtask

   task automatic step(input bit sp, input bit en, input bit rd, input bit clr);
      spike_in = sp; enable = en; rd_strobe = rd; clr_ovf = clr;
      @(posedge clk);
      model_clock();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1; spike_in = 1'b0; enable = 1'b0; rd_strobe = 1'b0; clr_ovf = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      check_all();
      reset = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp1[8];
      int exp2[4];
      exp1 = '{0, 0, 6, 4, 0, 0, 3, 2};
      exp2 = '{0, 0, 0, 15};

      // ISIs 100 and 50, drained nibble by nibble
      do_reset();
      idle(100);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(47);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
      for (int k = 0; k < 8; k++) begin
         chk("drain_nibble", 32'(nib_s), exp1[k]);
         step(1'b0, 1'b1, 1'b1, 1'b0);
      end
      chk("drain_empty", 32'(rv_s), 0);
      chk("drain_nibble_zero", 32'(nib_s), 0);

      // overflow, clear, push+pop on full
      do_reset();
      repeat (5) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      chk("five_full", 32'(full_s), 1);
      chk("five_overflow", 32'(ovf_s), 1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("clr_overflow", 32'(ovf_s), 0);
      repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("pushpop_overflow", 32'(ovf_s), 0);
      chk("pushpop_full", 32'(full_s), 1);
      step(1'b0, 1'b1, 1'b0, 1'b0);

      // level held 40 cycles gives one record
      do_reset();
      idle(10);
      repeat (40) step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(5);
      chk("held_one_record", 32'(rv_s), 1);
      repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("held_drained", 32'(rv_s), 0);

      // rising edge while disabled: no record, ISI frozen (10 + 5 = 15)
      do_reset();
      idle(10);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("disabled_no_record", 32'(rv_s), 0);
      idle(5);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk("frozen_isi_nibble", 32'(nib_s), exp2[k]);
         step(1'b0, 1'b1, 1'b1, 1'b0);
      end

      // 16-cycle window, edges at 3, 8 and the terminal cycle 15
      do_reset();
      for (int i = 0; i < 16; i++)
         step((i == 3 || i == 8 || i == 15), 1'b1, 1'b0, 1'b0);
      chk("window_rate", 32'(rate_s), 3);
      chk("window_valid", 32'(rvld_s), 1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("window_valid_drop", 32'(rvld_s), 0);
      chk("window_rate_hold", 32'(rate_s), 3);

      // 300 edges in a 1024-cycle window saturate
      do_reset();
      for (int i = 0; i < 1024; i++)
         step((i < 600 && (i % 2) == 0), 1'b1, 1'b0, 1'b0);
      chk("rate_saturate", 32'(rate_b), 255);
      chk("rate_saturate_valid", 32'(rvld_b), 1);

      // burst: ISIs 200, 40, 30 then 100
      do_reset();
      idle(200);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(39);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(29);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("burst_after_third", 32'(burst_s), BURST_ON ? 1 : 0);
      idle(99);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("burst_long_isi", 32'(burst_s), 0);

      // reset in the middle of a readout
      do_reset();
      idle(20);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(3);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("midread_valid", 32'(rv_s), 1);
      do_reset();
      chk("midread_reset_valid", 32'(rv_s), 0);
      chk("midread_reset_nibble", 32'(nib_s), 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if (($urandom % 600) == 0)
            do_reset();
         else
            step(($urandom % 3) == 0, ($urandom % 10) != 0,
                 ($urandom % 3) == 0, ($urandom % 20) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/adex_spike_monitor.md
# adex_spike_monitor

Downstream consumer of the AdEx neuron core's registered spike output. It edge-detects spikes and measures inter-spike intervals (ISI) in clock cycles. ISI records are buffered in a small FIFO that a host drains one nibble at a time. The block also reports a windowed spike rate and, optionally, a burst flag.

## Interface
Parameters:
- WINDOW_CYCLES, 4096: length of the rate window in enabled cycles (≥2).
- FIFO_DEPTH, 4: number of ISI records buffered (power of two, ≥2).
- BURST_ISI, 64: maximum ISI in cycles that counts as "short" (burst feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  counting enable; mirrors the core's enable.
- spike_in  in  1  level spike from the core; may stay high for several cycles.
- rd_strobe  in  1  single-cycle pulse; advances the nibble readout.
- clr_ovf  in  1  clears the sticky overflow flag.
- nibble_out  out  4  current nibble of the head record, MSB nibble first.
- rec_valid  out  1  FIFO not empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH records.
- overflow  out  1  sticky flag: a record was dropped.
- rate_out  out  8  spike count of the last completed window, saturating at 255.
- rate_valid  out  1  one-cycle pulse when rate_out updates.
- burst_out  out  1  burst indicator.

## Operation
- Edge detection: spike_prev <= spike_in every cycle, regardless of enable. Edge condition is spike_in & ~spike_prev & enable.
- ISI counter: 16-bit isi_cnt increments on each enabled cycle and saturates at 0xFFFF.
  - On an edge, the current isi_cnt is pushed and isi_cnt <= 1.
  - The first edge after reset pushes the cycle count since reset.
- FIFO: FIFO_DEPTH × 16 bits, with pointers that wrap around.
  - A push when full drops the new record and sets overflow.
  - A push and a pop in the same cycle while full: the pop frees a slot, the push is accepted, and overflow is not set.
- Readout: nib_idx (2 bits) selects head[15:12], [11:8], [7:4], [3:0] in that order.
  - rd_strobe with rec_valid=1 increments nib_idx. At nib_idx=3 it pops the record and resets nib_idx to 0.
  - rd_strobe with rec_valid=0 is ignored.
  - nibble_out = 0 when the FIFO is empty.
- Overflow: clr_ovf clears overflow. If set and clear occur in the same cycle, set wins.
- Rate: win_cnt counts enabled cycles from 0 to WINDOW_CYCLES-1. spk_cnt is 8-bit and saturating.
  - On the terminal cycle: rate_out <= sat(spk_cnt + edge), spk_cnt <= 0, win_cnt <= 0, rate_valid <= 1.
  - An edge on the terminal cycle is counted in the closing window.
- enable=0 freezes isi_cnt, win_cnt and spk_cnt. Readout and clr_ovf remain operational.

## Timing
- Every output resets to 0; the FIFO resets to empty with nib_idx=0.
- Edge at cycle N (spike_in=1 at N, 0 at N-1): rec_valid and fifo_full reflect the push at N+1, and the record equals isi_cnt as sampled at N.
- nibble_out is registered from FIFO state and updates the cycle after rd_strobe.
- A pop at cycle N updates rec_valid at N+1.
- rate_valid is high for exactly one cycle, the cycle after the terminal cycle, aligned with the new rate_out.
- Reset mid-readout discards all records and partial nibble state.

## Configuration
- ADEX_MON_BURST_EN defined:
  - A 2-bit saturating run_cnt updates on each edge: if the pushed ISI ≤ BURST_ISI, run_cnt increments; otherwise run_cnt <= 0.
  - burst_out = (run_cnt ≥ 2) and is registered, updating the cycle after the edge.
  - burst_out is cleared by reset and holds while enable=0.
- ADEX_MON_BURST_EN undefined: burst_out is tied to 0, BURST_ISI is unused, and no run_cnt logic is synthesized.

## Test plan
- Reset, enable=1, spike_in pulses (3 cycles high) rising at cycles 100 and 150 after reset -> records 100 and 50. Draining 8 strobes gives nibbles 0,0,6,4,0,0,3,2, after which rec_valid=0.
- Five edges with no reads -> four records kept, fifo_full=1, overflow=1. clr_ovf gives overflow=0. A simultaneous push and pop on a full FIFO gives no overflow.
- spike_in held high for 40 cycles -> exactly one record. enable=0 across a rising edge -> no record and isi_cnt frozen.
- WINDOW_CYCLES=16 with 3 edges in a window, one of them on the terminal cycle -> rate_out=3 with a single-cycle rate_valid. 300 edges in a large window -> rate_out=255.
- With ADEX_MON_BURST_EN and BURST_ISI=64: ISIs 200,40,30 -> burst_out=1 the cycle after the third edge. A following ISI of 100 -> burst_out=0. Without the macro, burst_out stays 0.
- Reset asserted after two of four strobes -> FIFO empty, nibble_out=0, all outputs 0 the next cycle.
